// File: rtl/nes_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nes_bus_pkg
// Brief   : Shared NES system-bus definitions (DMA states, default register
//           addresses, bus read/write encoding).
// Revision: 1.0 - initial release
// ============================================================================
package nes_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

  localparam logic [15:0] DMA_REG_ADDR_DEFAULT  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = 16'h2004;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module  : oam_dma
// Brief   : Sprite DMA; stalls the CPU and copies one 256-byte page to the
//           PPU OAM data port. Macro OAM_DMA_ODD_ALIGN_EN adds the ALIGN
//           cycle so every READ falls on an even tick.
// Revision: 1.0 - initial release
// ============================================================================
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEFAULT,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clk_en,
  input  logic        i_cpu_rw,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data,
  input  logic [7:0]  i_bus_data,
  output logic        o_cpu_clk_en,
  output logic        o_rw,
  output logic [15:0] o_address,
  output logic [7:0]  o_data,
  output logic        o_busy
);

  dma_state_e state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_buf_q, data_buf_d;
  logic       align_req;

`ifdef OAM_DMA_ODD_ALIGN_EN
  logic parity_q, parity_d;

  assign parity_d  = parity_q ^ i_clk_en;
  // HALT on an even tick would put READ on an odd one; pad with ALIGN.
  assign align_req = ~parity_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) parity_q <= 1'b0;
    else            parity_q <= parity_d;
  end
`else
  assign align_req = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      page_q     <= 8'h00;
      idx_q      <= 8'h00;
      data_buf_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      idx_q      <= idx_d;
      data_buf_q <= data_buf_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    idx_d        = idx_q;
    data_buf_d   = data_buf_q;
    o_rw         = i_cpu_rw;
    o_address    = i_cpu_address;
    o_data       = i_cpu_data;
    o_cpu_clk_en = i_clk_en;
    o_busy       = 1'b0;

    if (state_q != ST_IDLE) begin
      o_cpu_clk_en = 1'b0;
      o_busy       = 1'b1;
      o_data       = data_buf_q;
    end

    case (state_q)
      ST_IDLE: begin
        // The CPU's own register write still goes out on the bus this cycle.
        if (i_clk_en && (i_cpu_rw == RW_WRITE) && (i_cpu_address == DMA_REG_ADDR)) begin
          page_d  = i_cpu_data;
          idx_d   = 8'h00;
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        o_rw = RW_READ;
        if (i_clk_en) state_d = align_req ? ST_ALIGN : ST_READ;
      end
      ST_ALIGN: begin
        o_rw = RW_READ;
        if (i_clk_en) state_d = ST_READ;
      end
      ST_READ: begin
        o_rw      = RW_READ;
        o_address = {page_q, idx_q};
        if (i_clk_en) begin
          data_buf_d = i_bus_data;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        o_rw      = RW_WRITE;
        o_address = OAM_DATA_ADDR;
        if (i_clk_en) begin
          if (idx_q == 8'hFF) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// ============================================================================
// Module  : tb_oam_dma
// Brief   : Directed self-checking bench for oam_dma with a byte scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_oam_dma;
  import nes_bus_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_clk_en = 1'b1;
  logic        i_cpu_rw = 1'b1;
  logic [15:0] i_cpu_address = 16'h8000;
  logic [7:0]  i_cpu_data = 8'h00;
  logic [7:0]  i_bus_data;
  logic        o_cpu_clk_en;
  logic        o_rw;
  logic [15:0] o_address;
  logic [7:0]  o_data;
  logic        o_busy;

`ifdef OAM_DMA_ODD_ALIGN_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  int         n_checks = 0;
  int         n_fails  = 0;
  bit         par = 1'b0;
  logic [7:0] sb[$];

  oam_dma dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_clk_en      (i_clk_en),
    .i_cpu_rw      (i_cpu_rw),
    .i_cpu_address (i_cpu_address),
    .i_cpu_data    (i_cpu_data),
    .i_bus_data    (i_bus_data),
    .o_cpu_clk_en  (o_cpu_clk_en),
    .o_rw          (o_rw),
    .o_address     (o_address),
    .o_data        (o_data),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (a == 16'h0305) return 8'hA5;
    return (a[7:0] * 8'd7) ^ (a[15:8] + 8'h11);
  endfunction

  assign i_bus_data = mem_byte(o_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (i_clk_en && i_reset_n) par = ~par;
    #1;
  endtask

  task automatic idle_cycle(input logic rw, input logic [15:0] a, input logic [7:0] d);
    i_cpu_rw = rw; i_cpu_address = a; i_cpu_data = d;
    #1;
    chk("idle_busy", o_busy, 1'b0);
    chk("idle_cpu_en", o_cpu_clk_en, i_clk_en);
    chk("idle_rw", o_rw, rw);
    chk("idle_addr", o_address, a);
    if (rw == RW_WRITE) chk("idle_data", o_data, d);
    tick();
  endtask

  task automatic set_par(input bit want);
    if (par != want) idle_cycle(RW_READ, 16'h8000, 8'h00);
  endtask

  // freeze_byte / reset_byte < 0 disables that event.
  task automatic dma(input logic [7:0] pg, input int freeze_byte, input int reset_byte);
    bit          align;
    int          base, k, j, stall;
    logic [7:0]  bi, exp;
    logic [15:0] held;
    align = ALIGN_ON && par;
    base  = align ? 2 : 1;
    i_cpu_rw = RW_WRITE; i_cpu_address = 16'h4014; i_cpu_data = pg;
    #1;
    chk("trig_busy", o_busy, 1'b0);
    chk("trig_cpu_en", o_cpu_clk_en, 1'b1);
    chk("trig_rw", o_rw, RW_WRITE);
    chk("trig_addr", o_address, 16'h4014);
    chk("trig_data", o_data, pg);
    for (int i = 0; i < 256; i++) sb.push_back(mem_byte({pg, 8'(i)}));
    tick();
    i_cpu_rw = RW_READ; i_cpu_address = 16'h8000; i_cpu_data = 8'h00;
    #1;
    k = 0; stall = 0;
    while (o_busy === 1'b1 && k < 1000) begin
      chk("stall_cpu_en", o_cpu_clk_en, 1'b0);
      if (k < base) begin
        chk("dummy_rw", o_rw, RW_READ);
      end else begin
        j  = k - base;
        bi = 8'(j / 2);
        if (j % 2 == 0) begin
          chk("rd_rw", o_rw, RW_READ);
          chk("rd_addr", o_address, {pg, bi});
          if (int'(bi) == freeze_byte) begin
            held = o_address;
            i_clk_en = 1'b0;
            repeat (3) begin
              @(posedge i_clk); #1;
              chk("frz_addr", o_address, held);
              chk("frz_busy", o_busy, 1'b1);
              chk("frz_rw", o_rw, RW_READ);
            end
            i_clk_en = 1'b1;
            #1;
          end
          if (int'(bi) == reset_byte) begin
            i_reset_n = 1'b0;
            #1;
            chk("rst_busy", o_busy, 1'b0);
            chk("rst_cpu_en", o_cpu_clk_en, i_clk_en);
            chk("rst_addr", o_address, i_cpu_address);
            @(posedge i_clk); #1;
            i_reset_n = 1'b1;
            par = 1'b0;
            sb.delete();
            return;
          end
        end else begin
          chk("wr_rw", o_rw, RW_WRITE);
          chk("wr_addr", o_address, 16'h2004);
          exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
          chk("wr_data", o_data, exp);
          if (pg == 8'h03 && bi == 8'd5) chk("byte5_a5", o_data, 8'hA5);
        end
      end
      stall++;
      tick();
      k++;
    end
    chk("stall_len", stall, align ? 514 : 513);
    chk("post_cpu_en", o_cpu_clk_en, i_clk_en);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #2;
    chk("rst_busy0", o_busy, 1'b0);
    chk("rst_cpu_en0", o_cpu_clk_en, 1'b1);
    chk("rst_pass_addr", o_address, 16'h8000);
    i_clk_en = 1'b0; #1;
    chk("rst_cpu_en_follow", o_cpu_clk_en, 1'b0);
    i_clk_en = 1'b1;
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    par = 1'b0;

    idle_cycle(RW_WRITE, 16'h4013, 8'h55);
    idle_cycle(RW_READ,  16'h4014, 8'h00);
    idle_cycle(RW_READ,  16'h8000, 8'h00);

    set_par(1'b1); dma(8'h02, -1, -1);
    set_par(1'b0); dma(8'h02, -1, -1);
    idle_cycle(RW_READ, 16'h8001, 8'h00);
    dma(8'h03, -1, -1);
    dma(8'h04, 10, -1);
    dma(8'h05, -1, 100);
    idle_cycle(RW_READ, 16'h8002, 8'h00);
    dma(8'h05, -1, -1);
    idle_cycle(RW_READ, 16'h8003, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oam_dma.md
# oam_dma

Sprite DMA engine, directly downstream of the 6502 core on the NES system bus. It watches CPU writes for a write to the DMA register. On a hit it stalls the CPU through its clock enable and takes over the bus. It then copies 256 bytes from page `{data,8'h00}` to the PPU OAM data port and returns the bus to the CPU.

## Interface
Parameters:
- `DMA_REG_ADDR`, 16'h4014: CPU write address that triggers DMA.
- `OAM_DATA_ADDR`, 16'h2004: destination address for every DMA write.

Ports:
- `i_clk` in 1: system clock.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_clk_en` in 1: system tick; all state advances only on ticks.
- `i_cpu_rw` in 1: CPU read/write (1 = read).
- `i_cpu_address` in 16: CPU address.
- `i_cpu_data` in 8: CPU write data.
- `i_bus_data` in 8: read data returned by the memory map.
- `o_cpu_clk_en` out 1: clock enable to the CPU.
- `o_rw` out 1: bus read/write.
- `o_address` out 16: bus address.
- `o_data` out 8: bus write data.
- `o_busy` out 1: DMA owns the bus.

## Operation
- States: `IDLE`, `HALT`, `ALIGN`, `READ`, `WRITE`.
- **IDLE**
  - `o_rw`, `o_address` and `o_data` pass the CPU signals through combinationally.
  - `o_cpu_clk_en = i_clk_en`.
  - `o_busy = 0`.
- **Trigger**
  - Condition: a tick in `IDLE` with `i_cpu_rw=0` and `i_cpu_address==DMA_REG_ADDR`.
  - Action: latch `page <= i_cpu_data`, clear byte index `idx <= 0`, go to `HALT`.
  - The CPU's own write still completes on the bus in that cycle.
- **Outside IDLE**
  - `o_cpu_clk_en = 0`, `o_busy = 1`.
- **HALT**
  - Dummy cycle: `o_rw=1`, `o_address=` last CPU address.
  - Next state is `ALIGN` or `READ` (see Configuration).
- **ALIGN**
  - Dummy cycle, same outputs as `HALT`; always followed by `READ`.
- **READ**
  - `o_rw=1`, `o_address={page,idx}`.
  - At the tick: `buf <= i_bus_data`, go to `WRITE`.
- **WRITE**
  - `o_rw=0`, `o_address=OAM_DATA_ADDR`, `o_data=buf`.
  - At the tick: if `idx==8'hFF` go to `IDLE`, else `idx <= idx+1` and go to `READ`.
- Arithmetic: `idx` is 8-bit and never wraps in use, because termination occurs at 255. The source page is not incremented.
- Parity flop: toggles on every tick from reset, value 0 after reset. Tick "even" ⇔ parity==0.
- Without an `i_clk_en` tick, all state is frozen and outputs hold.
- A CPU write to `DMA_REG_ADDR` cannot occur while the DMA is busy, since the CPU is stalled. Bus activity seen while busy is ignored.

## Timing
- Reset values:
  - state `IDLE`, `page=0`, `idx=0`, `buf=0`, parity 0.
  - Outputs: `o_busy=0`, `o_cpu_clk_en=i_clk_en`, the rest pass-through.
- Reset asserted mid-transfer: state returns to `IDLE` immediately (asynchronous), the CPU is released and the transfer is abandoned.
- Latency, with the trigger at tick T:
  - `HALT` at T+1.
  - First `READ` at T+2, or T+3 with `ALIGN`.
  - Last `WRITE` at T+513 or T+514.
  - The CPU receives its next enabled tick at T+514 or T+515.
- Totals: 513 or 514 stall cycles.
- `o_cpu_clk_en` drops combinationally in the same cycle the state leaves `IDLE`. There is no extra enabled CPU tick.

## Configuration
- `OAM_DMA_ODD_ALIGN_EN` defined:
  - `ALIGN` is inserted when the `HALT` tick has even parity, so that every `READ` lands on an even tick.
  - Stall is 514 cycles for a trigger on an odd tick, 513 otherwise.
- Undefined:
  - `ALIGN` is never entered and the parity flop is omitted.
  - Stall is always 513 cycles.

## Structure
- Shared package `nes_bus_pkg`:
  - state encoding constants;
  - default `DMA_REG_ADDR`/`OAM_DATA_ADDR` values;
  - `RW_READ`/`RW_WRITE` constants, also used by the CPU wrapper.
- No sub-module: state register, `idx` counter, `buf` and the bus mux are kept flat in `oam_dma`.

## Test plan
- Write 8'h02 to 16'h4014 at an odd tick (macro on):
  - reads 16'h0200..16'h02FF alternate with writes to 16'h2004;
  - data matches memory;
  - `o_cpu_clk_en` is low for exactly 514 ticks.
- Same write at an even tick (macro on): 513 stall ticks and no `ALIGN`. With the macro off: 513 ticks on both odd and even triggers.
- Memory byte at 16'h0305 = 8'hA5, trigger page 8'h03: the 6th write to 16'h2004 carries 8'hA5.
- Idle traffic: CPU writes 8'h55 to 16'h4013 and reads 16'h4014. Required: pass-through unchanged, `o_busy` stays 0.
- `i_clk_en` low for 3 cycles in the middle of `READ`: address, state and `idx` hold; transfer completes with correct data.
- `i_reset_n` pulsed at byte 100: `o_busy=0` and `o_cpu_clk_en` follows `i_clk_en` immediately. A new trigger then restarts the transfer at `idx=0`.
